// File: rtl/hazard_ctrl.sv
// Hazard controller: EX operand forwarding selects, load-use stall, branch flush, MDU hold.
// Optional HAZ_PERF_EN adds saturating stall/flush event counters.
module hazard_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_regwrite,
  input  logic       ex_memread,
  input  logic [4:0] mem_rd,
  input  logic       mem_regwrite,
  input  logic       br_taken,
  input  logic       mdu_start,
  output logic       fwd_a_mem,
  output logic       fwd_a_wb,
  output logic       fwd_b_mem,
  output logic       fwd_b_wb,
  output logic       stall,
  output logic       id_bubble,
  output logic       ex_hold,
  output logic       flush
`ifdef HAZ_PERF_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  typedef enum logic [0:0] {StRun, StMduWait} state_e;

  // First wait-state count; the RUN cycle that starts the hold is the extra one.
  localparam logic [CNT_W-1:0] CntInit = CNT_W'((MDU_LAT > 1) ? (MDU_LAT - 2) : 0);
  localparam logic             MduMulti = (MDU_LAT > 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  logic ma_ex, ma_mem, mb_ex, mb_mem, lu;
  logic fa_mem_d, fa_wb_d, fb_mem_d, fb_wb_d;
  logic fwd_en;

  assign ma_ex  = id_use_rs & ex_regwrite  & (ex_rd  != 5'd0) & (id_rs == ex_rd);
  assign ma_mem = id_use_rs & mem_regwrite & (mem_rd != 5'd0) & (id_rs == mem_rd);
  assign mb_ex  = id_use_rt & ex_regwrite  & (ex_rd  != 5'd0) & (id_rt == ex_rd);
  assign mb_mem = id_use_rt & mem_regwrite & (mem_rd != 5'd0) & (id_rt == mem_rd);
  assign lu     = id_valid & ex_memread & (ma_ex | mb_ex);

  always_comb begin
    stall     = 1'b0;
    id_bubble = 1'b0;
    ex_hold   = 1'b0;
    flush     = 1'b0;
    if (state_q == StRun) begin
      flush     = br_taken;
      stall     = lu & ~br_taken;
      id_bubble = stall;
      // A starting MDU op overrides load-use; lu is re-evaluated once released.
      if (mdu_start && MduMulti) begin
        ex_hold   = 1'b1;
        stall     = 1'b1;
        id_bubble = 1'b0;
      end
    end else begin
      ex_hold = (cnt_q != '0);
      stall   = ex_hold;
    end
  end

  assign fa_mem_d = id_valid & ma_ex & ~ex_memread & ~stall & ~flush;
  assign fa_wb_d  = id_valid & ma_mem & ~fa_mem_d & ~stall & ~flush;
  assign fb_mem_d = id_valid & mb_ex & ~ex_memread & ~stall & ~flush;
  assign fb_wb_d  = id_valid & mb_mem & ~fb_mem_d & ~stall & ~flush;
  assign fwd_en   = (state_q == StRun) & ~ex_hold;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      fwd_a_mem <= 1'b0;
      fwd_a_wb  <= 1'b0;
      fwd_b_mem <= 1'b0;
      fwd_b_wb  <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ex_hold) begin
            cnt_q   <= CntInit;
            state_q <= StMduWait;
          end
        end
        StMduWait: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else             state_q <= StRun;
        end
      endcase
      if (fwd_en) begin
        fwd_a_mem <= fa_mem_d;
        fwd_a_wb  <= fa_wb_d;
        fwd_b_mem <= fb_mem_d;
        fwd_b_wb  <= fb_wb_d;
      end
    end
  end

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall && (perf_stall_cnt != 16'hFFFF)) perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (flush && (perf_flush_cnt != 16'hFFFF)) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule
